// File: rtl/bch_syndrome_solver.sv
// bch_syndrome_solver: serial syndrome accumulator and Peterson solver for
// the BCH(15,7) t=2 decoder over GF(16), p(x) = x^4 + x + 1.
// Bits arrive r14 first. S1 = r(a) and S3 = r(a^3) are built by Horner steps.
// The error-locator coefficients lambda1/lambda2 and the status flags are then
// handed to the Chien search stage over a valid/ready handshake.
// Optional macro BCH_SYND_DEBUG_EN adds the syn1/syn3 accumulator observation
// ports. Core behaviour is the same with or without it.
module bch_syndrome_solver #(
  parameter int N = 15,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_bit,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] lambda1,
  output logic [M-1:0] lambda2,
  output logic         no_error,
  output logic         uncorrectable
`ifdef BCH_SYND_DEBUG_EN
  ,
  output logic [M-1:0] syn1,
  output logic [M-1:0] syn3
`endif
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SOLVE   = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam logic [3:0] LAST_BIT = 4'(N - 1);

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [M-1:0] s1_q, s1_d;
  logic [M-1:0] s3_q, s3_d;
  logic         out_valid_q, out_valid_d;
  logic [M-1:0] lambda1_q, lambda1_d;
  logic [M-1:0] lambda2_q, lambda2_d;
  logic         no_error_q, no_error_d;
  logic         uncorrectable_q, uncorrectable_d;
  logic [M-1:0] lambda2_calc;

  // Multiply by a: shift up one power and fold a^4 back in as a + 1.
  function automatic logic [3:0] mul_alpha(input logic [3:0] a);
    return {a[2], a[1], a[0] ^ a[3], a[3]};
  endfunction

  // Multiply by a^3: three chained constant shifts, a pure XOR network.
  function automatic logic [3:0] mul_alpha3(input logic [3:0] a);
    return mul_alpha(mul_alpha(mul_alpha(a)));
  endfunction

  // Bit-parallel GF(16) multiply: shift-and-add with reduction at each shift.
  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] acc;
    logic [3:0] sh;
    acc = 4'd0;
    sh  = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = mul_alpha(sh);
    end
    return acc;
  endfunction

  // Multiplicative inverse table; 0 maps to 0 and is never used for division.
  function automatic logic [3:0] gf_inv(input logic [3:0] a);
    logic [3:0] r;
    case (a)
      4'h1:    r = 4'h1;
      4'h2:    r = 4'h9;
      4'h3:    r = 4'hE;
      4'h4:    r = 4'hD;
      4'h5:    r = 4'hB;
      4'h6:    r = 4'h7;
      4'h7:    r = 4'h6;
      4'h8:    r = 4'hF;
      4'h9:    r = 4'h2;
      4'hA:    r = 4'hC;
      4'hB:    r = 4'h5;
      4'hC:    r = 4'hA;
      4'hD:    r = 4'h4;
      4'hE:    r = 4'h3;
      4'hF:    r = 4'h8;
      default: r = 4'h0;
    endcase
    return r;
  endfunction

  // Peterson: lambda2 = S1^2 + S3/S1 (zero for a single error, since S3 = S1^3).
  assign lambda2_calc = gf_mul(s1_q, s1_q) ^ gf_mul(s3_q, gf_inv(s1_q));

  // Next-state logic: accumulate bits, solve once, then hold until accepted.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    s1_d            = s1_q;
    s3_d            = s3_q;
    out_valid_d     = out_valid_q;
    lambda1_d       = lambda1_q;
    lambda2_d       = lambda2_q;
    no_error_d      = no_error_q;
    uncorrectable_d = uncorrectable_q;
    case (state_q)
      COLLECT: begin
        if (in_valid) begin
          s1_d = mul_alpha(s1_q) ^ {3'b000, in_bit};
          s3_d = mul_alpha3(s3_q) ^ {3'b000, in_bit};
          if (cnt_q == LAST_BIT) begin
            cnt_d   = 4'd0;
            state_d = SOLVE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      SOLVE: begin
        out_valid_d     = 1'b1;
        state_d         = HOLD;
        no_error_d      = 1'b0;
        uncorrectable_d = 1'b0;
        if (s1_q != 4'd0) begin
          lambda1_d = s1_q;
          lambda2_d = lambda2_calc;
        end else begin
          lambda1_d = 4'd0;
          lambda2_d = 4'd0;
          if (s3_q == 4'd0) no_error_d = 1'b1;
          else              uncorrectable_d = 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          s1_d        = 4'd0;
          s3_d        = 4'd0;
          state_d     = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // State and output registers; reset drops any partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= COLLECT;
      cnt_q           <= 4'd0;
      s1_q            <= 4'd0;
      s3_q            <= 4'd0;
      out_valid_q     <= 1'b0;
      lambda1_q       <= 4'd0;
      lambda2_q       <= 4'd0;
      no_error_q      <= 1'b0;
      uncorrectable_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      s1_q            <= s1_d;
      s3_q            <= s3_d;
      out_valid_q     <= out_valid_d;
      lambda1_q       <= lambda1_d;
      lambda2_q       <= lambda2_d;
      no_error_q      <= no_error_d;
      uncorrectable_q <= uncorrectable_d;
    end
  end

  assign in_ready      = (state_q == COLLECT);
  assign out_valid     = out_valid_q;
  assign lambda1       = lambda1_q;
  assign lambda2       = lambda2_q;
  assign no_error      = no_error_q;
  assign uncorrectable = uncorrectable_q;

`ifdef BCH_SYND_DEBUG_EN
  assign syn1 = s1_q;
  assign syn3 = s3_q;
`endif

endmodule
